// File: rtl/rvj1_wb_master.sv
// Wishbone classic (B4) single-beat master bridging the rvj1 core req/gnt/rvalid data port.
// Optional bus timeout is built only when RVJ1_WBM_TIMEOUT_EN is defined.
module rvj1_wb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        busy_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        cyc_q;
    logic        rvalid_q;
    logic        tmo_hit;
    logic        unused_addr_lsb;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..65535");
    end

    // Byte lanes come only from be_i; the low address bits carry no information.
    assign unused_addr_lsb = ^addr_i[1:0];

`ifdef RVJ1_WBM_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LIMIT = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] TMO_MAX   = {CW{1'b1}};

    logic [CW-1:0] tmo_cnt_q;

    // Counts BUS cycles; cleared as a request is accepted, saturates instead of wrapping.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            tmo_cnt_q <= '0;
        end else if (state_q == IDLE && req_i) begin
            tmo_cnt_q <= '0;
        end else if (state_q == BUS && tmo_cnt_q != TMO_MAX) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign tmo_hit = (state_q == BUS) && (tmo_cnt_q == TMO_LIMIT);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            sel_q    <= 4'h0;
            adr_q    <= 32'h0;
            dat_q    <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            cyc_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rvalid_q <= 1'b0;
                    if (req_i) begin
                        we_q    <= we_i;
                        sel_q   <= be_i;
                        adr_q   <= {addr_i[31:2], 2'b00};
                        dat_q   <= wdata_i;
                        cyc_q   <= 1'b1;
                        state_q <= BUS;
                    end
                end
                BUS: begin
                    // err outranks ack, and ack outranks a coincident timeout.
                    if (wbm_err_i) begin
                        err_q    <= 1'b1;
                        rdata_q  <= 32'h0;
                        cyc_q    <= 1'b0;
                        rvalid_q <= 1'b1;
                        state_q  <= RESP;
                    end else if (wbm_ack_i) begin
                        err_q    <= 1'b0;
                        rdata_q  <= we_q ? 32'h0 : wbm_dat_i;
                        cyc_q    <= 1'b0;
                        rvalid_q <= 1'b1;
                        state_q  <= RESP;
                    end else if (tmo_hit) begin
                        err_q    <= 1'b1;
                        rdata_q  <= 32'h0;
                        cyc_q    <= 1'b0;
                        rvalid_q <= 1'b1;
                        state_q  <= RESP;
                    end
                end
                RESP: begin
                    rvalid_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    cyc_q    <= 1'b0;
                    rvalid_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign gnt_o     = req_i && (state_q == IDLE);
    assign busy_o    = (state_q != IDLE);
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign err_o     = err_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_rvj1_wb_master.sv
// Directed bench for rvj1_wb_master: read, write, error, timeout, reset abort and back-to-back.
// Inputs are driven on the falling edge and outputs sampled 1ns later.
module tb_rvj1_wb_master;

`ifdef RVJ1_WBM_TIMEOUT_EN
  localparam int unsigned TC = 8;
`else
  localparam int unsigned TC = 255;
`endif

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        busy;
  logic        cyc;
  logic        stb;
  logic        wb_we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack;
  logic        wb_err;

  int errors = 0;
  int checks = 0;

  rvj1_wb_master #(.TIMEOUT_CYCLES(TC)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .req_i     (req),
    .we_i      (we),
    .be_i      (be),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .gnt_o     (gnt),
    .rvalid_o  (rvalid),
    .rdata_o   (rdata),
    .err_o     (err),
    .busy_o    (busy),
    .wbm_cyc_o (cyc),
    .wbm_stb_o (stb),
    .wbm_we_o  (wb_we),
    .wbm_sel_o (sel),
    .wbm_adr_o (adr),
    .wbm_dat_o (dat_o),
    .wbm_dat_i (dat_i),
    .wbm_ack_i (ack),
    .wbm_err_i (wb_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 0; we = 0; be = 0; addr = 0; wdata = 0;
    dat_i = 0; ack = 0; wb_err = 0;
    repeat (3) next_cycle();
    settle();
    checks++; if (cyc !== 1'b0 || stb !== 1'b0) begin errors++; $display("FAIL reset_cyc: cyc=%b stb=%b want 0 0", cyc, stb); end
    checks++; if (rvalid !== 1'b0 || busy !== 1'b0 || gnt !== 1'b0) begin errors++; $display("FAIL reset_flags: rvalid=%b busy=%b gnt=%b want 0 0 0", rvalid, busy, gnt); end
    checks++; if (rdata !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL reset_capture: rdata=%h err=%b want 0 0", rdata, err); end
    checks++; if (adr !== 32'h0 || sel !== 4'h0 || wb_we !== 1'b0 || dat_o !== 32'h0) begin errors++; $display("FAIL reset_bus: adr=%h sel=%h we=%b dat=%h want zeros", adr, sel, wb_we, dat_o); end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_read();
    // T
    req = 1; we = 0; be = 4'hF; addr = 32'h3000_0010; wdata = 32'hAAAA_5555;
    settle();
    checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL read_gnt: gnt=%b want 1", gnt); end
    next_cycle(); // T+1
    req = 0; addr = 32'h0; be = 4'h0;
    settle();
    checks++; if (cyc !== 1'b1 || stb !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL read_cyc: cyc=%b stb=%b busy=%b want 1 1 1", cyc, stb, busy); end
    checks++; if (adr !== 32'h3000_0010 || wb_we !== 1'b0 || sel !== 4'hF) begin errors++; $display("FAIL read_bus: adr=%h we=%b sel=%h want 30000010 0 f", adr, wb_we, sel); end
    next_cycle(); // T+2
    next_cycle(); // T+3
    ack = 1; dat_i = 32'hDEAD_BEEF;
    settle();
    checks++; if (rvalid !== 1'b0 || cyc !== 1'b1) begin errors++; $display("FAIL read_wait: rvalid=%b cyc=%b want 0 1", rvalid, cyc); end
    next_cycle(); // T+4
    ack = 0; dat_i = 32'h0;
    settle();
    checks++; if (rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF || err !== 1'b0) begin errors++; $display("FAIL read_resp: rvalid=%b rdata=%h err=%b want 1 deadbeef 0", rvalid, rdata, err); end
    checks++; if (cyc !== 1'b0 || stb !== 1'b0 || gnt !== 1'b0) begin errors++; $display("FAIL read_drop: cyc=%b stb=%b gnt=%b want 0 0 0", cyc, stb, gnt); end
    next_cycle(); // T+5
    settle();
    checks++; if (rvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL read_idle: rvalid=%b busy=%b want 0 0", rvalid, busy); end
  endtask

  task automatic test_write();
    next_cycle();
    req = 1; we = 1; be = 4'b1100; addr = 32'h3000_4006; wdata = 32'h1234_5678;
    settle();
    checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL write_gnt: gnt=%b want 1", gnt); end
    next_cycle(); // T+1, zero-wait ack with garbage on dat_i
    req = 0; we = 0; wdata = 32'h0;
    ack = 1; dat_i = 32'hCAFE_F00D;
    settle();
    checks++; if (adr !== 32'h3000_4004 || dat_o !== 32'h1234_5678 || sel !== 4'hC || wb_we !== 1'b1) begin errors++; $display("FAIL write_bus: adr=%h dat=%h sel=%h we=%b want 30004004 12345678 c 1", adr, dat_o, sel, wb_we); end
    checks++; if (cyc !== 1'b1 || stb !== 1'b1) begin errors++; $display("FAIL write_cyc: cyc=%b stb=%b want 1 1", cyc, stb); end
    next_cycle(); // T+2
    ack = 0; dat_i = 32'h0;
    settle();
    checks++; if (rvalid !== 1'b1 || rdata !== 32'h0 || err !== 1'b0 || cyc !== 1'b0) begin errors++; $display("FAIL write_resp: rvalid=%b rdata=%h err=%b cyc=%b want 1 0 0 0", rvalid, rdata, err, cyc); end
    next_cycle();
  endtask

  task automatic test_error();
    next_cycle();
    req = 1; we = 0; be = 4'h3; addr = 32'h3000_0020;
    settle();
    checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL error_gnt: gnt=%b want 1", gnt); end
    next_cycle();
    req = 0;
    ack = 1; wb_err = 1; dat_i = 32'hFFFF_FFFF;
    next_cycle();
    ack = 0; wb_err = 0; dat_i = 32'h0;
    settle();
    checks++; if (rvalid !== 1'b1 || err !== 1'b1 || rdata !== 32'h0) begin errors++; $display("FAIL error_resp: rvalid=%b err=%b rdata=%h want 1 1 0", rvalid, err, rdata); end
    next_cycle();
    settle();
    checks++; if (rvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL error_idle: rvalid=%b busy=%b want 0 0", rvalid, busy); end
  endtask

  task automatic test_timeout();
    int rv_seen;
    next_cycle();
    req = 1; we = 0; be = 4'hF; addr = 32'h3000_0040;
    settle();
    checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL tmo_gnt: gnt=%b want 1", gnt); end
    next_cycle(); // T+1
    req = 0;
`ifdef RVJ1_WBM_TIMEOUT_EN
    rv_seen = 0;
    for (int c = 1; c <= 8; c++) begin
      settle();
      if (rvalid === 1'b1) rv_seen++;
      if (c < 8) next_cycle();
    end
    checks++; if (rv_seen != 0 || cyc !== 1'b1) begin errors++; $display("FAIL tmo_wait: early_rvalid=%0d cyc=%b want 0 1", rv_seen, cyc); end
    next_cycle(); // T+9
    settle();
    checks++; if (rvalid !== 1'b1 || err !== 1'b1 || rdata !== 32'h0) begin errors++; $display("FAIL tmo_resp: rvalid=%b err=%b rdata=%h want 1 1 0", rvalid, err, rdata); end
    checks++; if (cyc !== 1'b0 || stb !== 1'b0) begin errors++; $display("FAIL tmo_drop: cyc=%b stb=%b want 0 0", cyc, stb); end
    next_cycle(); // T+10
    next_cycle(); // T+11
    next_cycle(); // T+12: late ack
    ack = 1; dat_i = 32'h5A5A_5A5A;
    rv_seen = 0;
    for (int c = 0; c < 3; c++) begin
      settle();
      if (rvalid === 1'b1 || cyc === 1'b1) rv_seen++;
      next_cycle();
      ack = 0; dat_i = 32'h0;
    end
    checks++; if (rv_seen != 0 || busy !== 1'b0) begin errors++; $display("FAIL tmo_late_ack: activity=%0d busy=%b want 0 0", rv_seen, busy); end
`else
    repeat (999) next_cycle(); // T+1000
    settle();
    checks++; if (cyc !== 1'b1 || rvalid !== 1'b0) begin errors++; $display("FAIL notmo_wait: cyc=%b rvalid=%b want 1 0", cyc, rvalid); end
    next_cycle(); // T+1001
    ack = 1; dat_i = 32'h0BAD_CAFE;
    next_cycle(); // T+1002
    ack = 0; dat_i = 32'h0;
    settle();
    checks++; if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== 32'h0BAD_CAFE) begin errors++; $display("FAIL notmo_resp: rvalid=%b err=%b rdata=%h want 1 0 0badcafe", rvalid, err, rdata); end
    next_cycle();
`endif
  endtask

  task automatic test_reset_abort();
    int rv_seen;
    next_cycle();
    req = 1; we = 0; be = 4'hF; addr = 32'h3000_0080;
    settle();
    checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL abort_gnt: gnt=%b want 1", gnt); end
    next_cycle(); // T+1
    req = 0;
    next_cycle(); // T+2
    rst_n = 1'b0;
    settle();
    checks++; if (cyc !== 1'b0 || stb !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_drop: cyc=%b stb=%b busy=%b want 0 0 0", cyc, stb, busy); end
    next_cycle();
    rst_n = 1'b1;
    rv_seen = 0;
    for (int c = 0; c < 4; c++) begin
      settle();
      if (rvalid === 1'b1 || cyc === 1'b1) rv_seen++;
      next_cycle();
    end
    checks++; if (rv_seen != 0) begin errors++; $display("FAIL abort_no_rvalid: activity=%0d want 0", rv_seen); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] gnt_seen;
    logic [7:0] rv_seen;
    gnt_seen = '0;
    rv_seen  = '0;
    req = 1; we = 0; be = 4'hF; addr = 32'h3000_0100;
    ack = 1; dat_i = 32'h1111_2222;
    for (int c = 0; c < 8; c++) begin
      if (c == 4) req = 0;
      settle();
      gnt_seen[c] = gnt;
      rv_seen[c]  = rvalid;
      next_cycle();
    end
    ack = 0; dat_i = 32'h0;
    checks++; if (gnt_seen !== 8'b0000_1001) begin errors++; $display("FAIL b2b_gnt: pattern=%b want 00001001", gnt_seen); end
    checks++; if (rv_seen !== 8'b0010_0100) begin errors++; $display("FAIL b2b_rvalid: pattern=%b want 00100100", rv_seen); end
    checks++; if (rdata !== 32'h1111_2222 || err !== 1'b0) begin errors++; $display("FAIL b2b_data: rdata=%h err=%b want 11112222 0", rdata, err); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_error();
    test_timeout();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
